// File: rtl/product_accumulator.sv
// Signed 64-bit product accumulator: sums a run of len products from a valid/ready stream.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN clamps acc_out on signed overflow instead of wrapping.
module product_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             p_valid,
  input  logic [63:0]      p_data,
  output logic             p_ready,
  output logic [63:0]      acc_out,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [63:0]      sum_s;
  logic             ovf_s;

  // Clamp target: an overflow with negative operands saturates to the most negative value.
  function automatic logic [63:0] sat_value(input logic neg);
    sat_value = neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
  endfunction

  always_comb begin
    sum_s   = acc_q + p_data;
    ovf_s   = (acc_q[63] == p_data[63]) && (sum_s[63] != acc_q[63]);
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 64'd0;
          cnt_d   = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
          len_d   = len;
          state_d = (len == {CNT_W{1'b0}}) ? S_DONE : S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (p_valid) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_d = ovf_q | ovf_s;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
          acc_d = ovf_s ? sat_value(acc_q[63]) : sum_s;
`else
          acc_d = sum_s;
`endif
          if (cnt_d == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 64'd0;
      cnt_q   <= {CNT_W{1'b0}};
      len_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status outputs decode the state register only, so they never depend on p_valid.
  assign p_ready  = (state_q == S_ACCUM);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign acc_out  = acc_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios plus random runs vs. an arithmetic model.
module tb_product_accumulator;
  localparam int CNT_W = 8;
  localparam logic signed [64:0] MAX_S = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MIN_S = -65'sh0_8000_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             p_valid;
  logic [63:0]      p_data;
  logic             p_ready;
  logic [63:0]      acc_out;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             overflow;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] prod_q[$];
  logic [63:0] hold_acc;
  logic [63:0] hold_cnt;
  logic        hold_ovf;

  product_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid),
    .p_data(p_data), .p_ready(p_ready), .acc_out(acc_out), .count(count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run the products in prod_q as one accumulation; gap<0 means random idle gaps of 0..3 cycles.
  task automatic run_products(input int gap, input bit poke_start);
    int          n;
    int          g;
    logic [63:0] exp_acc;
    logic        exp_ovf;
    logic signed [64:0] ideal;
    n       = prod_q.size();
    exp_acc = 64'd0;
    exp_ovf = 1'b0;
    foreach (prod_q[i]) begin
      ideal = $signed({exp_acc[63], exp_acc}) + $signed({prod_q[i][63], prod_q[i]});
      if (ideal > MAX_S || ideal < MIN_S) exp_ovf = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      if (ideal > MAX_S)      exp_acc = 64'h7FFF_FFFF_FFFF_FFFF;
      else if (ideal < MIN_S) exp_acc = 64'h8000_0000_0000_0000;
      else                    exp_acc = ideal[63:0];
`else
      exp_acc = ideal[63:0];
`endif
    end
    // A product offered while idle must be dropped.
    p_valid = 1'b1;
    p_data  = 64'h0000_0000_0000_0123;
    tick();
    check("idle_drop_acc", acc_out, hold_acc);
    check("idle_drop_cnt", {56'd0, count}, hold_cnt);
    check("idle_busy", {63'd0, busy}, 64'd0);
    p_valid = 1'b0;
    start   = 1'b1;
    len     = n[CNT_W-1:0];
    tick();
    start = 1'b0;
    len   = 8'd0;
    check("start_acc_clr", acc_out, 64'd0);
    check("start_cnt_clr", {56'd0, count}, 64'd0);
    check("start_ovf_clr", {63'd0, overflow}, 64'd0);
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_ready", {63'd0, p_ready}, (n != 0) ? 64'd1 : 64'd0);
    for (int i = 0; i < n; i++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(3, 0));
      for (int k = 0; k < g; k++) begin
        p_valid = 1'b0;
        start   = poke_start;
        tick();
        check("gap_done", {63'd0, done}, 64'd0);
        check("gap_ready", {63'd0, p_ready}, 64'd1);
        check("gap_cnt", {56'd0, count}, 64'(i));
      end
      start   = 1'b0;
      p_valid = 1'b1;
      p_data  = prod_q[i];
      tick();
      if (i < n - 1) begin
        check("mid_done", {63'd0, done}, 64'd0);
        check("mid_cnt", {56'd0, count}, 64'(i + 1));
      end
    end
    p_valid = 1'b0;
    check("fin_done", {63'd0, done}, 64'd1);
    check("fin_acc", acc_out, exp_acc);
    check("fin_cnt", {56'd0, count}, 64'(n));
    check("fin_ovf", {63'd0, overflow}, {63'd0, exp_ovf});
    check("fin_ready", {63'd0, p_ready}, 64'd0);
    tick();
    check("post_done", {63'd0, done}, 64'd0);
    check("post_busy", {63'd0, busy}, 64'd0);
    check("post_acc", acc_out, exp_acc);
    check("post_ovf", {63'd0, overflow}, {63'd0, exp_ovf});
    hold_acc = exp_acc;
    hold_cnt = 64'(n);
    hold_ovf = exp_ovf;
  endtask

  initial begin
    logic [31:0] r;
    rst     = 1'b1;
    start   = 1'b0;
    len     = 8'd0;
    p_valid = 1'b0;
    p_data  = 64'd0;
    tick();
    tick();
    check("rst_acc", acc_out, 64'd0);
    check("rst_cnt", {56'd0, count}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_ready", {63'd0, p_ready}, 64'd0);
    rst      = 1'b0;
    hold_acc = 64'd0;
    hold_cnt = 64'd0;
    hold_ovf = 1'b0;

    // basic: three products of 616 * -81
    prod_q = {-64'sd49896, -64'sd49896, -64'sd49896};
    run_products(0, 1'b0);

    // backpressure: four idle cycles between products, start poked during the gaps
    prod_q = {64'sd1000, -64'sd250};
    run_products(4, 1'b1);

    // zero length run
    prod_q.delete();
    run_products(0, 1'b0);

    // signed overflow
    prod_q = {64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    run_products(0, 1'b0);

    // reset in the middle of a run
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_valid = 1'b1;
      p_data  = 64'd77;
      tick();
    end
    p_valid = 1'b0;
    check("mrst_pre_cnt", {56'd0, count}, 64'd2);
    rst = 1'b1;
    #1;
    check("mrst_acc", acc_out, 64'd0);
    check("mrst_cnt", {56'd0, count}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_ready", {63'd0, p_ready}, 64'd0);
    check("mrst_ovf", {63'd0, overflow}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_done", {63'd0, done}, 64'd0);
    end
    rst = 1'b0;
    tick();
    check("mrst_after_done", {63'd0, done}, 64'd0);
    hold_acc = 64'd0;
    hold_cnt = 64'd0;
    hold_ovf = 1'b0;
    prod_q = {64'sd5};
    run_products(0, 1'b0);

    // random runs: mix of small signed and full-range products
    for (int run = 0; run < 8; run++) begin
      prod_q.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) begin
        r = $urandom;
        if ($urandom_range(3, 0) == 0) prod_q.push_back({$urandom, $urandom});
        else                           prod_q.push_back({{32{r[31]}}, r});
      end
      run_products(-1, run[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the width of the product-count and length fields.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a new accumulation run.
REQ-005 The block SHALL have port len, input, CNT_W, the number of products in the run, sampled when start is accepted.
REQ-006 The block SHALL have port p_valid, input, 1, which marks p_data as valid.
REQ-007 The block SHALL have port p_data, input, 64, a signed two's-complement product from the upstream Multiplier P output.
REQ-008 The block SHALL have port p_ready, output, 1, which indicates the block accepts p_data this cycle.
REQ-009 The block SHALL have port acc_out, output, 64, the signed running or final sum.
REQ-010 The block SHALL have port count, output, CNT_W, the number of products accepted in the current run.
REQ-011 The block SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse when a run completes.
REQ-013 The block SHALL have port overflow, output, 1, a sticky flag for signed overflow during the current run.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-015 In IDLE with start=1 and len!=0, the block SHALL on the next edge: clear acc_out, count and overflow; latch len; enter ACCUM.
REQ-016 In IDLE with start=1 and len=0, the block SHALL: clear acc_out, count and overflow; enter DONE directly.
REQ-017 start SHALL be ignored in ACCUM and in DONE.
REQ-018 p_ready SHALL be 1 only in ACCUM and SHALL be combinational from the state only, never from p_valid.
REQ-019 A transfer SHALL occur on an edge where p_valid=1 and p_ready=1; on a transfer, acc_out <= acc_out + p_data (64-bit signed) and count <= count+1.
REQ-020 p_valid low in ACCUM SHALL hold all state; gaps of any length are legal.
REQ-021 The transfer that makes count equal the latched len SHALL move the FSM to DONE on that same edge.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-023 acc_out, count and overflow SHALL hold their final values in IDLE until the next accepted start.
REQ-024 Signed overflow SHALL be detected when both operands have the same sign and the sum sign differs; on detection, overflow SHALL set and remain set for the rest of the run.
REQ-025 Products with p_valid=1 outside ACCUM SHALL be dropped with no state change.
REQ-026 Latency from the final transfer to done=1 SHALL be exactly 1 cycle.

Reset
REQ-027 While rst=1, the block SHALL immediately force: state=IDLE, acc_out=0, count=0, busy=0, done=0, overflow=0, p_ready=0.
REQ-028 Reset asserted mid-run SHALL abandon the run; no done pulse SHALL be produced.
REQ-029 The first start accepted after rst deasserts SHALL behave per REQ-015 and REQ-016.

Configuration
REQ-030 With macro PRODUCT_ACCUMULATOR_SATURATE_EN defined, an overflowing transfer SHALL load acc_out with 64'h7FFF_FFFF_FFFF_FFFF (positive overflow) or 64'h8000_0000_0000_0000 (negative overflow), and later transfers SHALL add to the clamped value.
REQ-031 Without PRODUCT_ACCUMULATOR_SATURATE_EN, acc_out SHALL wrap modulo 2^64; overflow SHALL be flagged identically in both builds.

Verification
REQ-032 Bench scenario basic: start, len=3, three transfers of p_data=-49896 (616 * -81) with no gaps -> acc_out=-149688, count=3, done pulses 1 cycle after the third transfer, overflow=0.
REQ-033 Bench scenario backpressure: len=2 with products 1000 and -250 separated by 4 idle cycles; start pulsed again mid-run -> acc_out=750, a single done pulse, second start ignored.
REQ-034 Bench scenario overflow: len=2 with products 64'h7FFF_FFFF_FFFF_FFFF then 1 -> overflow=1; acc_out=64'h7FFF_FFFF_FFFF_FFFF with SATURATE_EN, 64'h8000_0000_0000_0000 without.
REQ-035 Bench scenario zero length: start, len=0 -> done on the next cycle, acc_out=0, count=0, p_ready never high.
REQ-036 Bench scenario reset mid-run: len=4, rst asserted after 2 transfers -> all outputs 0 immediately, no done pulse; a new run of len=1 with product 5 -> acc_out=5.
